// File: rtl/core_launcher.sv
// core_launcher
// Host-side sequencer for the processor core's req/done handshake.
//   1. LOAD  : streams LOAD_LEN operand bytes from the host stream into data
//              memory starting at LOAD_BASE (address wraps modulo 2**AW).
//   2. REQ   : pulses core_req for one cycle.
//   3. RUN   : waits for core_done. A done level left high by a previous run
//              is ignored until it has been seen low once (the "armed" flag).
//   4. DRAIN : streams RES_LEN result bytes out of data memory starting at
//              RES_BASE (address wraps modulo 2**AW).
//   5. FIN   : one-cycle finished pulse, then back to IDLE.
//
// Optional feature, macro WATCHDOG_EN:
//   A run-cycle counter cleared in REQ and incremented on every RUN cycle.
//   When TO_CYC RUN cycles elapse without a done, timeout is set (sticky
//   until the next accepted start) and the FSM skips DRAIN and goes to FIN.
//   Without the macro there is no counter, timeout is tied 0 and RUN waits
//   indefinitely.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-low reset
//   start      begin a run (honoured only in IDLE)
//   in_valid   load byte available          in_dat     load byte
//   in_ready   launcher accepts in_dat this cycle (LOAD only)
//   mem_wr_en  data memory write strobe     mem_addr   data memory address
//   mem_wr_dat data memory write data       mem_rd_dat combinational read data
//   core_req   one-cycle start pulse to core
//   core_done  core done level
//   out_valid  result byte available        out_dat    result byte
//   out_ready  consumer accepts out_dat
//   busy       high in every state except IDLE
//   finished   one-cycle pulse on completion
//   timeout    sticky watchdog flag
module core_launcher #(
  parameter int AW        = 8,
  parameter int LOAD_BASE = 0,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = 64,
  parameter int RES_LEN   = 32,
  parameter int TO_CYC    = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_dat,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_dat,
  input  logic [7:0]    mem_rd_dat,
  output logic          core_req,
  input  logic          core_done,
  output logic          out_valid,
  output logic [7:0]    out_dat,
  input  logic          out_ready,
  output logic          busy,
  output logic          finished,
  output logic          timeout
);

  // Elaboration-time guard on the configuration.
  if (AW < 1 || LOAD_LEN < 1 || LOAD_LEN > (1 << AW) ||
      RES_LEN < 1 || RES_LEN > (1 << AW) ||
      LOAD_BASE < 0 || RES_BASE < 0 || TO_CYC < 1) begin : g_param_check
    $error("core_launcher: parameter out of range");
  end

  // Bases are reduced to AW bits so base+idx wraps naturally.
  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);
  localparam logic [AW-1:0] LOAD_LAST   = AW'(LOAD_LEN - 1);
  localparam logic [AW-1:0] RES_LAST    = AW'(RES_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_REQ   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          armed, armed_nxt;
  logic          run_exit;
  logic          wd_expired;

  // Normal exit from RUN: done seen high after having been seen low.
  assign run_exit = (state == S_RUN) && armed && core_done;

`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(TO_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TO_CYC - 1);

  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == S_REQ) begin
      wd_cnt <= '0;
    end else if (state == S_RUN) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the TO_CYC-th RUN cycle; a simultaneous done wins.
  assign wd_expired = (state == S_RUN) && (wd_cnt == WD_LAST) && !run_exit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      timeout_q <= 1'b0;
    end else if (wd_expired) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      armed <= armed_nxt;
    end
  end

  // Outputs decode from the state register only (plus pass-through data),
  // so an asynchronous reset drops core_req / mem_wr_en immediately.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    armed_nxt  = armed;
    in_ready   = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wr_dat = '0;
    core_req   = 1'b0;
    out_valid  = 1'b0;
    out_dat    = '0;
    finished   = 1'b0;
    busy       = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
        end
      end

      S_LOAD: begin
        in_ready   = 1'b1;
        mem_addr   = LOAD_BASE_A + idx;
        mem_wr_dat = in_dat;
        mem_wr_en  = in_valid;
        if (in_valid) begin
          idx_nxt = idx + 1'b1;
          if (idx == LOAD_LAST) begin
            state_nxt = S_REQ;
            idx_nxt   = '0;
          end
        end
      end

      S_REQ: begin
        core_req  = 1'b1;
        armed_nxt = 1'b0;
        state_nxt = S_RUN;
      end

      S_RUN: begin
        if (!core_done) begin
          armed_nxt = 1'b1;
        end
        if (run_exit) begin
          state_nxt = S_DRAIN;
          idx_nxt   = '0;
        end else if (wd_expired) begin
          state_nxt = S_FIN;
        end
      end

      S_DRAIN: begin
        // idx only moves on a handshake, so address and data hold while stalled.
        mem_addr  = RES_BASE_A + idx;
        out_valid = 1'b1;
        out_dat   = mem_rd_dat;
        if (out_ready) begin
          idx_nxt = idx + 1'b1;
          if (idx == RES_LAST) begin
            state_nxt = S_FIN;
            idx_nxt   = '0;
          end
        end
      end

      S_FIN: begin
        finished  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
